// File: rtl/hk_pkg.sv
// Shared constants for hk_mem: SHA-256 H/K tables, RAM geometry and the copy sequencer states.
package hk_pkg;

  localparam int DATA_W    = 32;
  localparam int RAM_DEPTH = 128;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int H_BASE    = 0;
  localparam int K_BASE    = 64;
  localparam int H_WORDS   = 8;
  localparam int K_WORDS   = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY_H = 2'd1,
    COPY_K = 2'd2,
    DONE   = 2'd3
  } hk_state_e;

  // FIPS 180-4 initial hash values
  localparam logic [DATA_W-1:0] H_TABLE [H_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // FIPS 180-4 round constants
  localparam logic [DATA_W-1:0] K_TABLE [K_WORDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/hk_ram_bank.sv
// One 8-bit byte lane of the hk_mem RAM: synchronous write, asynchronous read.
module hk_ram_bank
  import hk_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [RAM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] buffer [RAM_DEPTH];

  // NOTE: storage has no reset; contents survive RESET_N and are only defined once written.
  always_ff @(posedge CLK) begin
    if (we) buffer[waddr] <= wdata;
  end

  assign rdata = buffer[raddr];

endmodule

// File: rtl/hk_mem.sv
// SHA-256 H/K constant store: copies ROM tables into a 4-bank RAM, then serves HK reads.
// Optional macro HK_MEM_READ_REG_EN registers the HK read port (one cycle latency).
module hk_mem
  import hk_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              COPY_ROM,
  output logic              COPY_ROM_COMPLETE,
  input  logic              HK_SELECTOR,
  input  logic [2:0]        H_ADDR,
  input  logic [5:0]        K_ADDR,
  output logic [DATA_W-1:0] HK
);

  hk_state_e         state, state_next;
  logic [5:0]        copy_cnt;
  logic              h_last, k_last;
  logic              wr_en;
  logic [RAM_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RAM_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign h_last = (copy_cnt == 6'(H_WORDS - 1));
  assign k_last = (copy_cnt == 6'(K_WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                         copy_cnt <= '0;
    else if (state == COPY_H && !h_last)  copy_cnt <= copy_cnt + 6'd1;
    else if (state == COPY_K && !k_last)  copy_cnt <= copy_cnt + 6'd1;
    else                                  copy_cnt <= '0;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    unique case (state)
      IDLE:   if (COPY_ROM) state_next = COPY_H;
      COPY_H: begin
        wr_en   = 1'b1;
        wr_addr = RAM_AW'(H_BASE + int'(copy_cnt));
        wr_data = H_TABLE[copy_cnt[2:0]];
        if (h_last) state_next = COPY_K;
      end
      COPY_K: begin
        wr_en   = 1'b1;
        wr_addr = RAM_AW'(K_BASE + int'(copy_cnt));
        wr_data = K_TABLE[copy_cnt];
        if (k_last) state_next = DONE;
      end
      DONE:   if (!COPY_ROM) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign COPY_ROM_COMPLETE = (state == DONE);

  assign rd_addr = HK_SELECTOR ? RAM_AW'(K_BASE + int'(K_ADDR))
                               : RAM_AW'(H_BASE + int'(H_ADDR));

  if (1) begin : RAM
    hk_ram_bank bank_1 (.CLK(CLK), .we(wr_en), .waddr(wr_addr), .wdata(wr_data[31:24]),
                        .raddr(rd_addr), .rdata(rd_data[31:24]));
    hk_ram_bank bank_2 (.CLK(CLK), .we(wr_en), .waddr(wr_addr), .wdata(wr_data[23:16]),
                        .raddr(rd_addr), .rdata(rd_data[23:16]));
    hk_ram_bank bank_3 (.CLK(CLK), .we(wr_en), .waddr(wr_addr), .wdata(wr_data[15:8]),
                        .raddr(rd_addr), .rdata(rd_data[15:8]));
    hk_ram_bank bank_4 (.CLK(CLK), .we(wr_en), .waddr(wr_addr), .wdata(wr_data[7:0]),
                        .raddr(rd_addr), .rdata(rd_data[7:0]));
  end

`ifdef HK_MEM_READ_REG_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) HK <= '0;
    else          HK <= rd_data;
  end
`else
  assign HK = rd_data;
`endif

endmodule

// File: tb/tb_hk_mem.sv
// Self-checking bench for hk_mem: copy timing, reset behaviour and H/K read sweeps via a scoreboard.
module tb_hk_mem;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        COPY_ROM;
  logic        COPY_ROM_COMPLETE;
  logic        HK_SELECTOR;
  logic [2:0]  H_ADDR;
  logic [5:0]  K_ADDR;
  logic [31:0] HK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] H_REF [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  hk_mem dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .COPY_ROM          (COPY_ROM),
    .COPY_ROM_COMPLETE (COPY_ROM_COMPLETE),
    .HK_SELECTOR       (HK_SELECTOR),
    .H_ADDR            (H_ADDR),
    .K_ADDR            (K_ADDR),
    .HK                (HK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges after the start edge until COMPLETE is seen high (bounded).
  task automatic count_to_complete(output int n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (COPY_ROM_COMPLETE === 1'b1) break;
    end
  endtask

  // Allows for the optional output register before sampling HK.
  task automatic settle_read();
`ifdef HK_MEM_READ_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; COPY_ROM = 1'b1; HK_SELECTOR = 1'b0; H_ADDR = '0; K_ADDR = '0;
    repeat (3) tick();
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b0) begin
      errors++; $display("FAIL reset_complete: got %b want 0", COPY_ROM_COMPLETE);
    end
`ifdef HK_MEM_READ_REG_EN
    checks++;
    if (HK !== 32'h0) begin
      errors++; $display("FAIL reset_hk_reg: got %h want 00000000", HK);
    end
`endif
  endtask

  // COPY_ROM already high at reset release: start edge is the next rising edge.
  task automatic test_copy_timing();
    int n;
    RESET_N = 1'b1;
    tick();
    count_to_complete(n);
    checks++;
    if (n !== 72) begin
      errors++; $display("FAIL copy_latency: got %0d cycles want 72", n);
    end
    repeat (5) tick();
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b1) begin
      errors++; $display("FAIL complete_hold: got %b want 1", COPY_ROM_COMPLETE);
    end
    COPY_ROM = 1'b0;
    #1;
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b1) begin
      errors++; $display("FAIL complete_before_edge: got %b want 1", COPY_ROM_COMPLETE);
    end
    tick();
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b0) begin
      errors++; $display("FAIL complete_clear: got %b want 0", COPY_ROM_COMPLETE);
    end
  endtask

  task automatic test_peek();
    logic [31:0] w;
    w = {dut.RAM.bank_1.buffer[3], dut.RAM.bank_2.buffer[3],
         dut.RAM.bank_3.buffer[3], dut.RAM.bank_4.buffer[3]};
    checks++;
    if (w !== 32'ha54ff53a) begin
      errors++; $display("FAIL peek_h3: got %h want a54ff53a", w);
    end
    w = {dut.RAM.bank_1.buffer[82], dut.RAM.bank_2.buffer[82],
         dut.RAM.bank_3.buffer[82], dut.RAM.bank_4.buffer[82]};
    checks++;
    if (w !== 32'h0fc19dc6) begin
      errors++; $display("FAIL peek_k18: got %h want 0fc19dc6", w);
    end
  endtask

  task automatic test_h_sweep();
    logic [31:0] exp;
    HK_SELECTOR = 1'b0;
    for (int i = 0; i < 9; i++) begin
      H_ADDR = 3'(i);
      exp_q.push_back(H_REF[i % 8]);
      settle_read();
      exp = exp_q.pop_front();
      checks++;
      if (HK !== exp) begin
        errors++; $display("FAIL h_read[%0d]: got %h want %h", i, HK, exp);
      end
    end
  endtask

  task automatic test_k_sweep();
    logic [31:0] exp;
    HK_SELECTOR = 1'b1;
    K_ADDR = 6'd63;
    for (int i = 0; i < 65; i++) begin
      K_ADDR = K_ADDR + 6'd1;
      exp_q.push_back(K_REF[i % 64]);
      settle_read();
      exp = exp_q.pop_front();
      checks++;
      if (HK !== exp) begin
        errors++; $display("FAIL k_read[%0d]: got %h want %h", i, HK, exp);
      end
    end
    K_ADDR = 6'd30;
    exp_q.push_back(32'h06ca6351);
    settle_read();
    exp = exp_q.pop_front();
    checks++;
    if (HK !== exp) begin
      errors++; $display("FAIL k_read30: got %h want %h", HK, exp);
    end
  endtask

  // COPY_ROM dropped early in COPY_H: copy still reaches DONE at 72, then returns to IDLE.
  task automatic test_drop_mid_copy();
    int n;
    COPY_ROM = 1'b1;
    tick();
    repeat (4) tick();
    COPY_ROM = 1'b0;
    count_to_complete(n);
    checks++;
    if (n !== 68) begin
      errors++; $display("FAIL drop_latency: got %0d cycles after drop want 68", n);
    end
    tick();
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b0) begin
      errors++; $display("FAIL drop_done_exit: got %b want 0", COPY_ROM_COMPLETE);
    end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    int seen;
    logic [7:0] b;
    COPY_ROM = 1'b1;
    tick();
    repeat (20) tick();
    RESET_N = 1'b0;
    #1;
    checks++;
    if (COPY_ROM_COMPLETE !== 1'b0) begin
      errors++; $display("FAIL midreset_complete: got %b want 0", COPY_ROM_COMPLETE);
    end
    b = dut.RAM.bank_1.buffer[3];
    checks++;
    if (b !== 8'ha5) begin
      errors++; $display("FAIL ram_not_reset: got %h want a5", b);
    end
    COPY_ROM = 1'b0;
    tick();
    RESET_N = 1'b1;
    seen = 0;
    repeat (80) begin
      tick();
      if (COPY_ROM_COMPLETE !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL no_resume: complete high %0d cycles want 0", seen);
    end
    COPY_ROM = 1'b1;
    tick();
    count_to_complete(n);
    checks++;
    if (n !== 72) begin
      errors++; $display("FAIL recopy_latency: got %0d cycles want 72", n);
    end
    COPY_ROM = 1'b0;
    tick();
  endtask

`ifdef HK_MEM_READ_REG_EN
  task automatic test_read_reg();
    HK_SELECTOR = 1'b0;
    H_ADDR = 3'd0;
    tick();
    H_ADDR = 3'd1;
    #1;
    checks++;
    if (HK !== 32'h6a09e667) begin
      errors++; $display("FAIL reg_hold: got %h want 6a09e667", HK);
    end
    tick();
    checks++;
    if (HK !== 32'hbb67ae85) begin
      errors++; $display("FAIL reg_latency: got %h want bb67ae85", HK);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_copy_timing();
    test_peek();
    test_h_sweep();
    test_k_sweep();
`ifdef HK_MEM_READ_REG_EN
    test_read_reg();
`endif
    test_drop_mid_copy();
    test_h_sweep();
    test_reset_mid_copy();
    test_k_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
